// File: rtl/tdc_calib_pkg.sv
// tdc_calib_pkg: FSM states and default sizing for the TDC delay calibration controller
package tdc_calib_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_EVAL, S_DONE} state_t;
  localparam int DEF_W_VAL    = 8;
  localparam int DEF_W_DLY    = 5;
  localparam int DEF_LOG2_AVG = 4;
  localparam int DEF_SETTLE   = 8;
endpackage

// File: rtl/tdc_calib_accum.sv
// tdc_calib_accum: sums 2^LOG2_AVG samples, pulsing done_o on the final one
module tdc_calib_accum
  import tdc_calib_pkg::*;
#(
  parameter int W_VAL    = DEF_W_VAL,
  parameter int LOG2_AVG = DEF_LOG2_AVG
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      en,
  input  logic [W_VAL-1:0]          value,
  output logic [W_VAL+LOG2_AVG-1:0] acc_o,
  output logic                      done_o
);
  logic [LOG2_AVG-1:0]       cnt_q, cnt_d;
  logic [W_VAL+LOG2_AVG-1:0] acc_q, acc_d;
  always_comb begin
    cnt_d  = clear ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    acc_d  = clear ? '0 : en ? acc_q + {{LOG2_AVG{1'b0}}, value} : acc_q;
    done_o = en && (cnt_q == '1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/tdc_calib_ctrl.sv
// tdc_calib_ctrl: sweeps the coarse delay, keeps the setting whose mean is closest to target; TDC_CALIB_EARLY_EXIT_EN stops on zero error
module tdc_calib_ctrl
  import tdc_calib_pkg::*;
#(
  parameter int W_VAL    = DEF_W_VAL,
  parameter int W_DLY    = DEF_W_DLY,
  parameter int LOG2_AVG = DEF_LOG2_AVG,
  parameter int SETTLE   = DEF_SETTLE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [W_VAL-1:0] target_i,
  input  logic [W_VAL-1:0] tdc_value_i,
  output logic [W_DLY-1:0] dly_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [W_DLY-1:0] best_dly_o,
  output logic [W_VAL-1:0] best_err_o
);
  state_t                    state_q, state_d;
  logic [7:0]                set_q, set_d;
  logic [W_DLY-1:0]          dly_q, dly_d, restore_q, restore_d;
  logic [W_DLY-1:0]          cand_dly_q, cand_dly_d, best_dly_q, best_dly_d;
  logic [W_VAL-1:0]          target_q, target_d, cand_err_q, cand_err_d, best_err_q, best_err_d;
  logic [W_VAL+LOG2_AVG-1:0] acc;
  logic                      acc_done, active, upd, last;
  logic [W_VAL-1:0]          mean, err, win_err;
  logic [W_DLY-1:0]          win_dly;
  tdc_calib_accum #(.W_VAL(W_VAL), .LOG2_AVG(LOG2_AVG)) u_accum (
    .clock (clock),
    .reset (reset),
    .clear (state_q != S_ACCUM),
    .en    (state_q == S_ACCUM),
    .value (tdc_value_i),
    .acc_o (acc),
    .done_o(acc_done)
  );
  always_comb begin
    active  = (state_q == S_SETTLE) || (state_q == S_ACCUM) || (state_q == S_EVAL);
    mean    = W_VAL'(acc >> LOG2_AVG);
    err     = (mean >= target_q) ? mean - target_q : target_q - mean;
    upd     = err < cand_err_q;
    win_dly = upd ? dly_q : cand_dly_q;
    win_err = upd ? err : cand_err_q;
`ifdef TDC_CALIB_EARLY_EXIT_EN
    last    = (dly_q == '1) || (err == '0);
`else
    last    = (dly_q == '1);
`endif
    state_d    = state_q;
    set_d      = set_q;
    dly_d      = dly_q;
    restore_d  = restore_q;
    target_d   = target_q;
    cand_dly_d = cand_dly_q;
    cand_err_d = cand_err_q;
    best_dly_d = best_dly_q;
    best_err_d = best_err_q;
    if (active && abort_i) begin
      state_d = S_IDLE;
      set_d   = '0;
      dly_d   = restore_q;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          target_d   = target_i;
          restore_d  = dly_q;
          dly_d      = '0;
          cand_dly_d = '0;
          cand_err_d = '1;
          state_d    = S_SETTLE;
        end
        S_SETTLE: begin
          set_d   = (set_q == 8'(SETTLE - 1)) ? '0 : set_q + 8'd1;
          state_d = (set_q == 8'(SETTLE - 1)) ? S_ACCUM : S_SETTLE;
        end
        S_ACCUM: state_d = acc_done ? S_EVAL : S_ACCUM;
        S_EVAL: begin
          cand_dly_d = win_dly;
          cand_err_d = win_err;
          if (last) begin
            state_d    = S_DONE;
            dly_d      = win_dly;
            best_dly_d = win_dly;
            best_err_d = win_err;
          end else begin
            state_d = S_SETTLE;
            dly_d   = dly_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      set_q      <= '0;
      dly_q      <= '0;
      restore_q  <= '0;
      target_q   <= '0;
      cand_dly_q <= '0;
      cand_err_q <= '0;
      best_dly_q <= '0;
      best_err_q <= '0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      dly_q      <= dly_d;
      restore_q  <= restore_d;
      target_q   <= target_d;
      cand_dly_q <= cand_dly_d;
      cand_err_q <= cand_err_d;
      best_dly_q <= best_dly_d;
      best_err_q <= best_err_d;
    end
  end
  assign dly_o      = dly_q;
  assign busy_o     = active;
  assign done_o     = state_q == S_DONE;
  assign best_dly_o = best_dly_q;
  assign best_err_o = best_err_q;
endmodule
